fmul_exception_pack: RTL

FMUL_EXCEPTION_PACK -- requirements
Module: fmul_exception_pack

---
 rtl/fmul_exception_pack.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fmul_exception_pack.sv
// Final packing stage of a floating-point multiplier: resolves special-operand
// and range exceptions into an encoded result, queues it in a 2-entry in-order
// buffer with valid/busy handshake, and accumulates sticky exception flags.
module fmul_exception_pack #(
  parameter int unsigned P_EXP_W   = 11,
  parameter int unsigned P_FRACT_W = 24
) (
  input  logic                              iCLOCK,
  input  logic                              inRESET,
  input  logic                              iRESET_SYNC,
  input  logic                              iDATA_VALID,
  output logic                              oDATA_BUSY,
  input  logic                              iDATA_SIGN,
  input  logic [P_EXP_W+1:0]                iDATA_EXP,
  input  logic [P_FRACT_W:0]                iDATA_FRACT,
  input  logic [1:0]                        iDATA_A_CLASS,
  input  logic [1:0]                        iDATA_B_CLASS,
  output logic                              oDATA_VALID,
  input  logic                              iDATA_BUSY,
  output logic [P_EXP_W+P_FRACT_W:0]        oDATA,
  output logic [2:0]                        oDATA_FLAGS,
  input  logic                              iFLAG_CLEAR,
  output logic [2:0]                        oSTICKY_FLAGS
);

  localparam int unsigned W     = 1 + P_EXP_W + P_FRACT_W;
  localparam int unsigned ENT_W = W + 3;

  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  localparam logic [P_FRACT_W-1:0] NAN_FRACT = {1'b1, {(P_FRACT_W-1){1'b0}}};

  // Entry layout: {flags[2:0], sign, exp, fract}; flags = {invalid, overflow, underflow}
  logic [ENT_W-1:0] ent0_q, ent0_d;
  logic [ENT_W-1:0] ent1_q, ent1_d;
  logic [1:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [2:0]       sticky_q, sticky_d;

  logic [P_EXP_W-1:0]   res_exp;
  logic [P_FRACT_W-1:0] res_fract;
  logic [2:0]           res_flags;
  logic [ENT_W-1:0]     new_ent;
  logic                 push, pop;
  logic [1:0]           cnt_after_pop;

  // Exception resolution: first matching rule wins
  always_comb begin
    res_exp   = iDATA_EXP[P_EXP_W-1:0];
    res_fract = iDATA_FRACT[P_FRACT_W-1:0];
    res_flags = 3'b000;
    if (iDATA_A_CLASS == CLS_NAN || iDATA_B_CLASS == CLS_NAN) begin
      res_exp   = '1;
      res_fract = NAN_FRACT;
    end else if ((iDATA_A_CLASS == CLS_ZERO && iDATA_B_CLASS == CLS_INF) ||
                 (iDATA_A_CLASS == CLS_INF  && iDATA_B_CLASS == CLS_ZERO)) begin
      res_exp   = '1;
      res_fract = NAN_FRACT;
      res_flags = 3'b100;
    end else if (iDATA_A_CLASS == CLS_INF || iDATA_B_CLASS == CLS_INF) begin
      res_exp   = '1;
      res_fract = '0;
    end else if (iDATA_A_CLASS == CLS_ZERO || iDATA_B_CLASS == CLS_ZERO) begin
      res_exp   = '0;
      res_fract = '0;
    end else if (iDATA_EXP[P_EXP_W+1]) begin
      // Underflow wins over a simultaneous overflow indication
      res_exp   = '0;
      res_fract = '0;
      res_flags = 3'b001;
    end else if (iDATA_EXP[P_EXP_W]) begin
      res_exp   = '1;
      res_fract = '0;
      res_flags = 3'b010;
    end
    new_ent = {res_flags, iDATA_SIGN, res_exp, res_fract};
  end

  // Buffer/handshake next state; unoccupied slots are kept at zero so the
  // head register doubles as the zeroed output when the buffer is empty
  always_comb begin
    push          = iDATA_VALID && !busy_q;
    pop           = valid_q && !iDATA_BUSY;
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    sticky_d      = sticky_q;
    cnt_after_pop = count_q - 2'(pop);
    if (pop) begin
      ent0_d = ent1_q;
      ent1_d = '0;
    end
    if (push) begin
      if (cnt_after_pop == 2'd0) ent0_d = new_ent;
      else                       ent1_d = new_ent;
    end
    count_d = cnt_after_pop + 2'(push);
    if (iFLAG_CLEAR)  sticky_d = push ? res_flags : 3'b000;
    else if (push)    sticky_d = sticky_q | res_flags;
    if (iRESET_SYNC) begin
      ent0_d   = '0;
      ent1_d   = '0;
      count_d  = 2'd0;
      sticky_d = 3'b000;
    end
    valid_d = (count_d != 2'd0);
    busy_d  = (count_d == 2'd2);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      count_q  <= 2'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sticky_q <= 3'b000;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      sticky_q <= sticky_d;
    end
  end

  assign oDATA_VALID   = valid_q;
  assign oDATA_BUSY    = busy_q;
  assign oDATA         = ent0_q[W-1:0];
  assign oDATA_FLAGS   = ent0_q[ENT_W-1:W];
  assign oSTICKY_FLAGS = sticky_q;

endmodule
